// File: rtl/bus1_if.sv
// C1 bus (A1/D1/C1) as seen by the arbiter and by the cache side.
// Outputs carry an enable; the tristate wrapper turns them into 'z when not enabled.
interface bus1_if #(
   parameter int ADDR1_BUS_SIZE = 15,
   parameter int DATA1_BUS_SIZE = 16,
   parameter int CTR1_BUS_SIZE  = 3
);
   logic [ADDR1_BUS_SIZE-1:0] A1_OUT;
   logic [CTR1_BUS_SIZE-1:0]  C1_OUT;
   logic                      A1_OE;
   logic [DATA1_BUS_SIZE-1:0] D1_OUT;
   logic                      D1_OE;
   logic [CTR1_BUS_SIZE-1:0]  C1_IN;
   logic [DATA1_BUS_SIZE-1:0] D1_IN;

   modport master (
      output A1_OUT, C1_OUT, A1_OE, D1_OUT, D1_OE,
      input  C1_IN, D1_IN
   );

   modport slave (
      input  A1_OUT, C1_OUT, A1_OE, D1_OUT, D1_OE,
      output C1_IN, D1_IN
   );
endinterface

// File: rtl/bus1_arbiter.sv
// Round-robin arbiter and C1 protocol sequencer for the CPU<->Cache bus.
// One requester at a time gets a two-cycle command/address phase, then the
// bus is released until the cache answers with C1_RESPONSE (or a timeout).
module bus1_arbiter #(
   parameter int NREQ              = 2,
   parameter int CACHE_TAG_SIZE    = 10,
   parameter int CACHE_SET_SIZE    = 5,
   parameter int CACHE_OFFSET_SIZE = 4,
   parameter int ADDR1_BUS_SIZE    = 15,
   parameter int DATA1_BUS_SIZE    = 16,
   parameter int CTR1_BUS_SIZE     = 3,
   parameter int TIMEOUT           = 255,
   localparam int ADDR_W = CACHE_TAG_SIZE + CACHE_SET_SIZE + CACHE_OFFSET_SIZE
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*3-1:0]      cmd,
   input  logic [NREQ*ADDR_W-1:0] addr,
   input  logic [NREQ*32-1:0]     wdata,
   output logic [NREQ-1:0]        done,
   output logic                   err,
   output logic [31:0]            rdata,
   output logic                   busy,
   bus1_if.master                 bus
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic [2:0] {
      C1_NOP      = 3'd0,
      C1_READ8    = 3'd1,
      C1_READ16   = 3'd2,
      C1_READ32   = 3'd3,
      C1_WRITE8   = 3'd4,
      C1_WRITE16  = 3'd5,
      C1_WRITE32  = 3'd6,
      C1_RESPONSE = 3'd7
   } c1_code_t;

   typedef enum logic [2:0] {
      IDLE,
      CMD1,
      CMD2,
      WAIT,
      RESP2,
      DONE
   } state_t;

   state_t                       state;
   logic [IW-1:0]                rr_ptr;
   logic [IW-1:0]                gnt;
   logic [2:0]                   cmd_q;
   logic [CACHE_OFFSET_SIZE-1:0] off_q;
   logic [15:0]                  wd_hi_q;
   logic [7:0]                   timer;

   logic                         found;
   logic [IW-1:0]                gidx;
   logic [2:0]                   sel_cmd;
   logic [ADDR_W-1:0]            sel_addr;
   logic [31:0]                  sel_wdata;
   logic                         sel_write;

   // Round-robin search starting after the last grant, plus a mux of the winner's command.
   always_comb begin : arb
      int unsigned idx;
      logic [IW-1:0] cand;
      found     = 1'b0;
      gidx      = '0;
      idx       = 0;
      cand      = '0;
      sel_cmd   = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx  = (32'(rr_ptr) + k) % NREQ;
         cand = IW'(idx);
         if (!found && req[cand]) begin
            found = 1'b1;
            gidx  = cand;
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gidx == IW'(i)) begin
            sel_cmd   = cmd[3*i +: 3];
            sel_addr  = addr[ADDR_W*i +: ADDR_W];
            sel_wdata = wdata[32*i +: 32];
         end
      end
      sel_write = (sel_cmd == C1_WRITE8) || (sel_cmd == C1_WRITE16) || (sel_cmd == C1_WRITE32);
   end

   // Transaction FSM; every output is registered and set for the state being entered.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IDLE;
         rr_ptr     <= IW'(NREQ - 1);
         gnt        <= '0;
         cmd_q      <= '0;
         off_q      <= '0;
         wd_hi_q    <= '0;
         timer      <= '0;
         done       <= '0;
         err        <= 1'b0;
         rdata      <= '0;
         busy       <= 1'b0;
         bus.A1_OE  <= 1'b0;
         bus.D1_OE  <= 1'b0;
         bus.A1_OUT <= '0;
         bus.C1_OUT <= '0;
         bus.D1_OUT <= '0;
      end else begin
         done <= '0;
         case (state)
            IDLE: begin
               if (found) begin
                  rr_ptr  <= gidx;
                  gnt     <= gidx;
                  cmd_q   <= sel_cmd;
                  off_q   <= sel_addr[CACHE_OFFSET_SIZE-1:0];
                  wd_hi_q <= sel_wdata[31:16];
                  timer   <= '0;
                  busy    <= 1'b1;
                  if (sel_cmd == C1_NOP || sel_cmd == C1_RESPONSE) begin
                     // Not a bus command: complete with an error, never touch the bus.
                     done[gidx] <= 1'b1;
                     err        <= 1'b1;
                     state      <= DONE;
                  end else begin
                     state      <= CMD1;
                     bus.A1_OE  <= 1'b1;
                     bus.C1_OUT <= CTR1_BUS_SIZE'(sel_cmd);
                     bus.A1_OUT <= ADDR1_BUS_SIZE'(sel_addr[ADDR_W-1:CACHE_OFFSET_SIZE]);
                     bus.D1_OE  <= sel_write;
                     if (sel_cmd == C1_WRITE8)
                        bus.D1_OUT <= DATA1_BUS_SIZE'({8'h00, sel_wdata[7:0]});
                     else if (sel_write)
                        bus.D1_OUT <= DATA1_BUS_SIZE'(sel_wdata[15:0]);
                  end
               end
            end
            CMD1: begin
               state      <= CMD2;
               bus.A1_OUT <= ADDR1_BUS_SIZE'(off_q);
               if (cmd_q == C1_WRITE32)
                  bus.D1_OUT <= DATA1_BUS_SIZE'(wd_hi_q);
            end
            CMD2: begin
               state     <= WAIT;
               bus.A1_OE <= 1'b0;
               bus.D1_OE <= 1'b0;
            end
            WAIT: begin
               if (bus.C1_IN == CTR1_BUS_SIZE'(C1_RESPONSE)) begin
                  case (cmd_q)
                     C1_READ8:  rdata <= {24'h0, bus.D1_IN[7:0]};
                     C1_READ16: rdata <= {16'h0, bus.D1_IN[15:0]};
                     C1_READ32: rdata[15:0] <= bus.D1_IN[15:0];
                     default: ;
                  endcase
                  if (cmd_q == C1_READ32) begin
                     state <= RESP2;
                  end else begin
                     done[gnt] <= 1'b1;
                     err       <= 1'b0;
                     state     <= DONE;
                  end
               end else if (timer == 8'(TIMEOUT)) begin
                  done[gnt] <= 1'b1;
                  err       <= 1'b1;
                  state     <= DONE;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            RESP2: begin
               rdata[31:16] <= bus.D1_IN[15:0];
               done[gnt]    <= 1'b1;
               err          <= 1'b0;
               state        <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
